// File: rtl/csr_wr_sched.sv
// CSR write scheduler: arbitrates the single CSR-file write port between
// WB-stage CSR writes and the multi-cycle trap-entry / MRET update sequences.
module csr_wr_sched #(
   parameter int RSZ     = 32,
   parameter int MIE_BIT = 3
) (
   input  logic            clk_in,
   input  logic            reset_n_in,
   input  logic            wb_csr_wr,
   input  logic [11:0]     wb_csr_addr,
   input  logic [RSZ-1:0]  wb_csr_data,
   output logic            wb_ready,
   input  logic            trap_req,
   input  logic [RSZ-1:0]  trap_pc,
   input  logic [RSZ-1:0]  trap_cause,
   input  logic [RSZ-1:0]  trap_tval,
   input  logic            mret_req,
   input  logic [1:0]      mode,
   input  logic [RSZ-1:0]  mstatus_rd,
   output logic            csr_we,
   output logic [11:0]     csr_waddr,
   output logic [RSZ-1:0]  csr_wdata,
   output logic            trap_ack,
   output logic            mret_ack,
   output logic            busy
);

   localparam int MPIE_BIT = 7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MEPC    = 3'd1,
      MCAUSE  = 3'd2,
      MTVAL   = 3'd3,
      MSTAT_T = 3'd4,
      MSTAT_R = 3'd5
   } state_e;

   state_e         state_q, state_d;
   logic [RSZ-1:0] pc_q, pc_d;
   logic [RSZ-1:0] cause_q, cause_d;
   logic [RSZ-1:0] tval_q, tval_d;
   logic [RSZ-1:0] mstat_trap, mstat_mret;

   // mstatus images written on trap entry and on MRET, built from the live value
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later lines see earlier results;
      // only clocked state uses '<='.
      mstat_trap              = mstatus_rd;
      mstat_trap[MPIE_BIT]    = mstatus_rd[MIE_BIT];
      mstat_trap[MIE_BIT]     = 1'b0;
      mstat_trap[12:11]       = mode;

      mstat_mret              = mstatus_rd;
      mstat_mret[MIE_BIT]     = mstatus_rd[MPIE_BIT];
      mstat_mret[MPIE_BIT]    = 1'b1;
      mstat_mret[12:11]       = 2'b00;
   end

   // Next-state, trap-value capture and write-port mux
   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      cause_d   = cause_q;
      tval_d    = tval_q;
      wb_ready  = 1'b0;
      csr_we    = 1'b0;
      csr_waddr = '0;
      csr_wdata = '0;
      trap_ack  = 1'b0;
      mret_ack  = 1'b0;

      case (state_q)
         IDLE: begin
            // The older WB instruction commits in the same cycle a request is accepted.
            wb_ready  = 1'b1;
            csr_we    = wb_csr_wr;
            csr_waddr = wb_csr_addr;
            csr_wdata = wb_csr_data;
            if (trap_req) begin
               state_d = MEPC;
               pc_d    = trap_pc;
               cause_d = trap_cause;
               tval_d  = trap_tval;
            end else if (mret_req) begin
               state_d = MSTAT_R;
            end
         end
         MEPC: begin
            csr_we    = 1'b1;
            csr_waddr = 12'h341;
            csr_wdata = {pc_q[RSZ-1:2], 2'b00};
            state_d   = MCAUSE;
         end
         MCAUSE: begin
            csr_we    = 1'b1;
            csr_waddr = 12'h342;
            csr_wdata = cause_q;
            state_d   = MTVAL;
         end
         MTVAL: begin
            csr_we    = 1'b1;
            csr_waddr = 12'h343;
            csr_wdata = tval_q;
            state_d   = MSTAT_T;
         end
         MSTAT_T: begin
            csr_we    = 1'b1;
            csr_waddr = 12'h300;
            csr_wdata = mstat_trap;
            trap_ack  = 1'b1;
            state_d   = IDLE;
         end
         MSTAT_R: begin
            csr_we    = 1'b1;
            csr_waddr = 12'h300;
            csr_wdata = mstat_mret;
            mret_ack  = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // NOTE: reset is asynchronous, so outputs are also forced while it is held,
      // not just from the next edge; otherwise a WB write would leak out in reset.
      if (!reset_n_in) begin
         wb_ready  = 1'b1;
         csr_we    = 1'b0;
         csr_waddr = '0;
         csr_wdata = '0;
         trap_ack  = 1'b0;
         mret_ack  = 1'b0;
      end
   end

   assign busy = reset_n_in && (state_q != IDLE);

   // State and latched trap values
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      // NOTE: the latched trap values are plain registers, cleared in reset so an
      // aborted sequence leaves no stale data behind.
      if (!reset_n_in) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
      end
   end

endmodule

// File: tb/tb_csr_wr_sched.sv
// Self-checking bench for csr_wr_sched: a transaction-level reference model
// queues expected CSR writes; a negedge monitor pops and compares them.
module tb_csr_wr_sched;

   localparam int RSZ = 32;

   logic            clk_in      = 1'b0;
   logic            reset_n_in  = 1'b0;
   logic            wb_csr_wr   = 1'b0;
   logic [11:0]     wb_csr_addr = '0;
   logic [RSZ-1:0]  wb_csr_data = '0;
   logic            wb_ready;
   logic            trap_req    = 1'b0;
   logic [RSZ-1:0]  trap_pc     = '0;
   logic [RSZ-1:0]  trap_cause  = '0;
   logic [RSZ-1:0]  trap_tval   = '0;
   logic            mret_req    = 1'b0;
   logic [1:0]      mode        = '0;
   logic [RSZ-1:0]  mstatus_rd  = '0;
   logic            csr_we;
   logic [11:0]     csr_waddr;
   logic [RSZ-1:0]  csr_wdata;
   logic            trap_ack;
   logic            mret_ack;
   logic            busy;

   csr_wr_sched #(.RSZ(RSZ), .MIE_BIT(3)) dut (
      .clk_in      (clk_in),
      .reset_n_in  (reset_n_in),
      .wb_csr_wr   (wb_csr_wr),
      .wb_csr_addr (wb_csr_addr),
      .wb_csr_data (wb_csr_data),
      .wb_ready    (wb_ready),
      .trap_req    (trap_req),
      .trap_pc     (trap_pc),
      .trap_cause  (trap_cause),
      .trap_tval   (trap_tval),
      .mret_req    (mret_req),
      .mode        (mode),
      .mstatus_rd  (mstatus_rd),
      .csr_we      (csr_we),
      .csr_waddr   (csr_waddr),
      .csr_wdata   (csr_wdata),
      .trap_ack    (trap_ack),
      .mret_ack    (mret_ack),
      .busy        (busy)
   );

   always #5 clk_in = ~clk_in;

   typedef enum int {OP_PLAIN, OP_MSTAT_TRAP, OP_MSTAT_MRET} op_kind_e;

   typedef struct {
      logic [11:0]    addr;
      logic [RSZ-1:0] data;
      op_kind_e       kind;
   } op_t;

   typedef struct {
      logic [11:0]    addr;
      logic [RSZ-1:0] data;
      logic           tack;
      logic           mack;
   } wr_t;

   op_t pend[$];    // writes the scheduler still owes, one per busy cycle
   wr_t exp_q[$];   // expected CSR-file writes, in order
   bit  rdy_q[$];   // expected wb_ready, one per cycle out of reset

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: scoreboard had no expectation at %0t", name, $time);
   endtask

   // Reference model: one call per non-reset cycle, with this cycle's inputs.
   task automatic model();
      op_t o;
      wr_t w;
      if (pend.size() == 0) begin
         rdy_q.push_back(1'b1);
         if (wb_csr_wr) begin
            w.addr = wb_csr_addr; w.data = wb_csr_data; w.tack = 1'b0; w.mack = 1'b0;
            exp_q.push_back(w);
         end
         if (trap_req) begin
            o.kind = OP_PLAIN;
            o.addr = 12'h341; o.data = trap_pc & ~32'h3; pend.push_back(o);
            o.addr = 12'h342; o.data = trap_cause;       pend.push_back(o);
            o.addr = 12'h343; o.data = trap_tval;        pend.push_back(o);
            o.addr = 12'h300; o.data = '0; o.kind = OP_MSTAT_TRAP; pend.push_back(o);
         end else if (mret_req) begin
            o.addr = 12'h300; o.data = '0; o.kind = OP_MSTAT_MRET; pend.push_back(o);
         end
      end else begin
         rdy_q.push_back(1'b0);
         o = pend.pop_front();
         w.addr = o.addr; w.data = o.data; w.tack = 1'b0; w.mack = 1'b0;
         if (o.kind == OP_MSTAT_TRAP) begin
            // MPIE <- MIE, MIE <- 0, MPP <- current mode
            w.data = mstatus_rd;
            w.data[7] = mstatus_rd[3];
            w.data[3] = 1'b0;
            w.data[12:11] = mode;
            w.tack = 1'b1;
         end else if (o.kind == OP_MSTAT_MRET) begin
            // MIE <- MPIE, MPIE <- 1, MPP <- U
            w.data = mstatus_rd;
            w.data[3] = mstatus_rd[7];
            w.data[7] = 1'b1;
            w.data[12:11] = 2'b00;
            w.mack = 1'b1;
         end
         exp_q.push_back(w);
      end
   endtask

   // Monitor: samples on the falling edge, pops expectations as the DUT presents writes.
   always @(negedge clk_in) begin
      wr_t w;
      bit  r;
      if (!reset_n_in) begin
         check("rst_we",    csr_we,    1'b0);
         check("rst_ready", wb_ready,  1'b1);
         check("rst_waddr", csr_waddr, 12'h0);
         check("rst_wdata", csr_wdata, 32'h0);
         check("rst_flags", {trap_ack, mret_ack, busy}, 3'b000);
      end else begin
         if (rdy_q.size() == 0) fail_now("ready_sync");
         else begin
            r = rdy_q.pop_front();
            check("wb_ready", wb_ready, r);
            check("busy", busy, !r);
         end
         if (csr_we) begin
            if (exp_q.size() == 0) fail_now("unexpected_write");
            else begin
               w = exp_q.pop_front();
               check("waddr", csr_waddr, w.addr);
               check("wdata", csr_wdata, w.data);
               check("trap_ack", trap_ack, w.tack);
               check("mret_ack", mret_ack, w.mack);
            end
         end else begin
            check("ack_without_write", {trap_ack, mret_ack}, 2'b00);
         end
      end
   end

   task automatic apply();
      model();
      #2;
   endtask

   task automatic next_cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic cyc();
      apply();
      next_cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a WB write pending: outputs must stay quiet
      reset_n_in  = 1'b0;
      wb_csr_wr   = 1'b1;
      wb_csr_addr = 12'h305;
      wb_csr_data = 32'h100;
      next_cyc();
      next_cyc();
      reset_n_in = 1'b1;

      // Plain WB write in IDLE goes straight through
      apply();
      check("wb_direct_we",    csr_we,    1'b1);
      check("wb_direct_addr",  csr_waddr, 12'h305);
      check("wb_direct_data",  csr_wdata, 32'h100);
      check("wb_direct_ready", wb_ready,  1'b1);
      next_cyc();

      // Trap entry; request dropped right after acceptance
      wb_csr_wr  = 1'b0;
      trap_req   = 1'b1;
      trap_pc    = 32'h8000_0102;
      trap_cause = 32'h2;
      trap_tval  = 32'h13;
      mode       = 2'd3;
      mstatus_rd = 32'h8;
      cyc();
      trap_req   = 1'b0;
      trap_pc    = 32'hdead_beef;
      apply(); check("trap_mepc",   csr_wdata, 32'h8000_0100); next_cyc();
      apply(); check("trap_mcause", csr_wdata, 32'h2);         next_cyc();
      apply(); check("trap_mtval",  csr_wdata, 32'h13);        next_cyc();
      apply();
      check("trap_mstatus", csr_wdata, 32'h1880);
      check("trap_ack_4th", trap_ack, 1'b1);
      next_cyc();

      // Trap and WB write in the same IDLE cycle: WB first, then stall 4 cycles
      wb_csr_wr   = 1'b1;
      wb_csr_addr = 12'h340;
      wb_csr_data = 32'hA5;
      trap_req    = 1'b1;
      trap_pc     = 32'h1000;
      apply();
      check("same_cycle_wb_addr", csr_waddr, 12'h340);
      check("same_cycle_wb_data", csr_wdata, 32'hA5);
      next_cyc();
      wb_csr_wr = 1'b0;
      trap_req  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply();
         check("stall_ready", wb_ready, 1'b0);
         next_cyc();
      end

      // Trap and MRET together: trap first, MRET accepted once IDLE again
      trap_req   = 1'b1;
      mret_req   = 1'b1;
      mode       = 2'd0;
      mstatus_rd = 32'h80;
      cyc();
      trap_req = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      cyc();
      apply();
      check("mret_mstatus", csr_wdata, 32'h88);
      check("mret_ack",     mret_ack,  1'b1);
      next_cyc();
      mret_req = 1'b0;

      // Reset during MCAUSE abandons the sequence
      trap_req = 1'b1;
      cyc();
      trap_req = 1'b0;
      cyc();
      reset_n_in = 1'b0;
      #1;
      check("mid_reset_we",  csr_we,   1'b0);
      check("mid_reset_ack", trap_ack, 1'b0);
      pend.delete();
      next_cyc();
      next_cyc();
      reset_n_in = 1'b1;
      apply();
      check("post_reset_idle", busy, 1'b0);
      next_cyc();

      // WB write held through a trap sequence: written again only once IDLE
      wb_csr_wr   = 1'b1;
      wb_csr_addr = 12'h344;
      wb_csr_data = 32'h55;
      trap_req    = 1'b1;
      cyc();
      trap_req = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      apply();
      check("held_wb_ready", wb_ready,  1'b1);
      check("held_wb_addr",  csr_waddr, 12'h344);
      next_cyc();
      wb_csr_wr = 1'b0;

      // Randomized traffic, with occasional resets
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(299) == 0) begin
            reset_n_in = 1'b0;
            pend.delete();
            next_cyc();
            reset_n_in = 1'b1;
         end
         wb_csr_wr   = $urandom_range(1);
         wb_csr_addr = 12'($urandom);
         wb_csr_data = $urandom;
         trap_req    = ($urandom_range(5) == 0);
         mret_req    = ($urandom_range(3) == 0);
         trap_pc     = $urandom;
         trap_cause  = $urandom;
         trap_tval   = $urandom;
         mode        = 2'($urandom);
         mstatus_rd  = $urandom;
         cyc();
      end

      // Drain
      wb_csr_wr = 1'b0;
      trap_req  = 1'b0;
      mret_req  = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
      check("drain_exp_empty",  exp_q.size(), 0);
      check("drain_pend_empty", pend.size(),  0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_wr_sched.md
CSR_WR_SCHED -- requirements
Module: csr_wr_sched

Interface
REQ-001 SHALL have parameter RSZ, default 32, CSR/register data width.
REQ-002 SHALL have parameter MIE_BIT, default 3, mstatus.MIE position; MPIE = 7, MPP = [12:11] are fixed.
REQ-003 SHALL have clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have reset_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have wb_csr_wr  input  1  WB stage requests a CSR write.
REQ-006 SHALL have wb_csr_addr  input  12  WB CSR write address.
REQ-007 SHALL have wb_csr_data  input  RSZ  WB CSR write data.
REQ-008 SHALL have wb_ready  output  1  WB write accepted this cycle; 0 means pipeline stall.
REQ-009 SHALL have trap_req  input  1  trap entry request, held until trap_ack.
REQ-010 SHALL have trap_pc, trap_cause, trap_tval  input  RSZ each  values for mepc, mcause, mtval.
REQ-011 SHALL have mret_req  input  1  MRET request, held until mret_ack.
REQ-012 SHALL have mode  input  2  current privilege mode.
REQ-013 SHALL have mstatus_rd  input  RSZ  current mstatus (0x300) contents.
REQ-014 SHALL have csr_we  output  1  CSR file write enable.
REQ-015 SHALL have csr_waddr  output  12  CSR file write address.
REQ-016 SHALL have csr_wdata  output  RSZ  CSR file write data.
REQ-017 SHALL have trap_ack, mret_ack  output  1 each  single-cycle completion pulses.
REQ-018 SHALL have busy  output  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, MEPC, MCAUSE, MTVAL, MSTAT_T, MSTAT_R.
REQ-020 IDLE: wb_ready = 1; csr_we/waddr/wdata = wb_csr_wr/addr/data combinationally.
REQ-021 IDLE, trap_req = 1 at edge -> MEPC; latch trap_pc/cause/tval into internal registers that edge.
REQ-022 IDLE, mret_req = 1 and trap_req = 0 at edge -> MSTAT_R; trap_req wins when both are set.
REQ-023 WB write present in the accepting IDLE cycle SHALL still complete that cycle, because the older instruction commits first.
REQ-024 Non-IDLE states: wb_ready = 0; WB write not performed; WB inputs ignored.
REQ-025 MEPC: write 0x341 = latched pc with bits[1:0] forced 0; next MCAUSE.
REQ-026 MCAUSE: write 0x342 = latched cause; next MTVAL.
REQ-027 MTVAL: write 0x343 = latched tval; next MSTAT_T.
REQ-028 MSTAT_T: write 0x300 = mstatus_rd with MPIE = old MIE, MIE = 0, MPP = mode; trap_ack = 1; next IDLE.
REQ-029 MSTAT_R: write 0x300 = mstatus_rd with MIE = old MPIE, MPIE = 1, MPP = 2'b00; mret_ack = 1; next IDLE.
REQ-030 csr_we SHALL be 1 in every non-IDLE state; exactly one CSR write occurs per cycle.
REQ-031 Trap latency: acceptance edge + 4 write cycles; trap_ack is coincident with the 4th write.
REQ-032 MRET latency: acceptance edge + 1 write cycle, with mret_ack coincident.
REQ-033 Deassertion of trap_req or mret_req after acceptance SHALL NOT abort the sequence.
REQ-034 Request still high in the IDLE cycle after an ack SHALL be accepted again, because requesters deassert on ack.
REQ-035 Latched trap registers SHALL NOT change outside the acceptance edge.
REQ-036 No unlisted state; an illegal encoding SHALL return to IDLE next edge.

Reset
REQ-037 reset_n_in low SHALL asynchronously force IDLE and clear latched registers to 0.
REQ-038 During reset: csr_we = 0, trap_ack = 0, mret_ack = 0, busy = 0, wb_ready = 1, csr_waddr = 0, csr_wdata = 0.
REQ-039 Reset mid-sequence SHALL abandon remaining writes with no ack; first edge after release is in IDLE.

Verification
REQ-040 WB write 0x305 = 0x00000100, no requests -> same-cycle csr_we = 1, waddr = 0x305, wdata = 0x100, wb_ready = 1.
REQ-041 trap_req with pc = 0x80000102, cause = 0x2, tval = 0x13, mode = 3, mstatus_rd = 0x8 -> writes 0x341 = 0x80000100, 0x342 = 2, 0x343 = 0x13, 0x300 = 0x1880 on consecutive cycles, with trap_ack in the 4th.
REQ-042 trap_req and wb_csr_wr (0x340 = 0xA5) in the same IDLE cycle -> 0x340 written that cycle; trap writes follow; wb_ready = 0 for 4 cycles.
REQ-043 trap_req and mret_req together, mstatus_rd = 0x80 -> trap sequence first, then MRET sequence; MRET write 0x300 = 0x88 when mstatus_rd is 0x80 at that time.
REQ-044 reset_n_in low during MCAUSE -> csr_we drops immediately; no trap_ack; IDLE after release.
REQ-045 wb_csr_wr held high through the trap sequence -> no WB write until IDLE, then written once with wb_ready = 1.
